// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/loader memory bus arbiter.
// Holds the FSM encoding, port and direction IDs, and the burst-count update rule.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Locked loader grants extend the burst (saturating); anything else restarts it.
  function automatic cnt_t burst_next(input cnt_t cnt, input logic port,
                                      input logic lock, input cnt_t max_burst);
    if (port == PORT_LDR && lock) begin
      return (cnt >= max_burst) ? max_burst : cnt + cnt_t'(1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_grant_picker.sv
// Combinational winner select between the CPU and loader ports.
// Round-robin on contention, except that a locked loader keeps the bus until its burst is spent.
module mem_grant_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic p0_req,
  input  logic p1_req,
  input  logic p1_lock,
  input  logic last_served,
  input  cnt_t burst_cnt,
  output logic grant_valid,
  output logic grant_port
);

  logic lock_active;

  assign lock_active = (last_served == PORT_LDR) && p1_lock &&
                       (burst_cnt < CNT_W'(MAX_BURST));

  always_comb begin
    grant_valid = p0_req | p1_req;
    grant_port  = PORT_CPU;
    if (p0_req && p1_req) begin
      grant_port = lock_active ? PORT_LDR : ~last_served;
    end else if (p1_req) begin
      grant_port = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the CPU controller (port 0) and the loader (port 1).
// Sequences a single registered access per grant and returns read data with an ack pulse.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  input  logic          p1_req,
  input  logic          p1_lock,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] rdata,
  output logic          owner,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $fatal(1, "mem_bus_arbiter: MEM_LAT must be in 1..15");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $fatal(1, "mem_bus_arbiter: MAX_BURST must be in 1..15");
  end

  state_e        state_q, state_d;
  cnt_t          lat_cnt_q, lat_cnt_d;
  cnt_t          burst_cnt_q, burst_cnt_d;
  logic          last_served_q, last_served_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;

  logic grant_valid;
  logic grant_port;
  logic lat_done;

  mem_grant_picker #(
    .MAX_BURST (MAX_BURST)
  ) u_picker (
    .p0_req      (p0_req),
    .p1_req      (p1_req),
    .p1_lock     (p1_lock),
    .last_served (last_served_q),
    .burst_cnt   (burst_cnt_q),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign lat_done = (lat_cnt_q == CNT_W'(MEM_LAT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lat_cnt_q     <= '0;
      burst_cnt_q   <= '0;
      last_served_q <= PORT_LDR;
      owner_q       <= PORT_CPU;
      busy_q        <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_rw_q      <= RW_READ;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
      owner_q       <= owner_d;
      busy_q        <= busy_d;
      mem_en_q      <= mem_en_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (lat_done) state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    lat_cnt_d     = lat_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    last_served_d = last_served_q;
    owner_d       = owner_q;
    mem_en_d      = 1'b0;
    mem_rw_d      = mem_rw_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d       = grant_port;
          last_served_d = grant_port;
          burst_cnt_d   = burst_next(burst_cnt_q, grant_port, p1_lock, CNT_W'(MAX_BURST));
          lat_cnt_d     = '0;
          mem_en_d      = 1'b1;
          mem_rw_d      = (grant_port == PORT_CPU) ? p0_rw    : p1_rw;
          mem_addr_d    = (grant_port == PORT_CPU) ? p0_addr  : p1_addr;
          mem_wdata_d   = (grant_port == PORT_CPU) ? p0_wdata : p1_wdata;
        end
      end
      ST_ACCESS: begin
        if (lat_done) begin
          if (mem_rw_q != RW_WRITE) rdata_d = mem_rdata;
          mem_rw_d = RW_READ;
          p0_ack_d = (owner_q == PORT_CPU);
          p1_ack_d = (owner_q == PORT_LDR);
        end else begin
          lat_cnt_d = lat_cnt_q + cnt_t'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
